// File: rtl/wavegen_pkg.sv
// Shared waveform encodings and the sine half-wave clamp used by every channel's shaper.
package wavegen_pkg;

  localparam logic [1:0] WAVE_SAW = 2'd0;
  localparam logic [1:0] WAVE_SQR = 2'd1;
  localparam logic [1:0] WAVE_TRI = 2'd2;
  localparam logic [1:0] WAVE_SIN = 2'd3;

  // Limit a parabolic half-wave magnitude to the largest code that fits in half the sample range.
  function automatic logic [31:0] sine_clamp(input logic [31:0] h, input int s);
    logic [31:0] lim;
    lim = (32'd1 << (s - 1)) - 32'd1;
    return (h > lim) ? lim : h;
  endfunction

endpackage

// File: rtl/wavegen_pwm_mc_if.sv
// Control and PWM/sample bus of the multi-channel waveform synthesiser.
interface wavegen_pwm_mc_if #(
  parameter int NCH      = 2,
  parameter int FREQ_W   = 12,
  parameter int SAMPLE_W = 8
);
  logic                     en;
  logic                     phase_clr;
  logic [NCH*FREQ_W-1:0]    freq;
  logic [NCH*2-1:0]         wave_sel;
  logic [NCH-1:0]           pwm;
  logic [NCH*SAMPLE_W-1:0]  sample;
  logic                     period_tick;
  logic [NCH-1:0]           act_led;

  modport master (
    output en, phase_clr, freq, wave_sel,
    input  pwm, sample, period_tick, act_led
  );

  modport slave (
    input  en, phase_clr, freq, wave_sel,
    output pwm, sample, period_tick, act_led
  );
endinterface

// File: rtl/wave_shaper.sv
// Maps one channel's phase to a registered unsigned sample: saw, square, triangle or parabolic sine.
module wave_shaper
  import wavegen_pkg::*;
#(
  parameter int PHASE_W  = 16,
  parameter int SAMPLE_W = 8
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [PHASE_W-1:0]  phase,
  input  logic [1:0]          wave_sel,
  output logic [SAMPLE_W-1:0] wave_p1
);

  localparam logic [SAMPLE_W-1:0] FULL    = '1;
  localparam logic [SAMPLE_W-1:0] HALF_M1 = FULL >> 1;
  localparam logic [SAMPLE_W-1:0] HALF    = HALF_M1 + 1'b1;

  logic                  m;
  logic [SAMPLE_W-1:0]   p;
  logic [SAMPLE_W-1:0]   x;
  logic [2*SAMPLE_W-1:0] prod;
  logic [2*SAMPLE_W-1:0] prod_sh;
  logic [31:0]           h_sat;
  logic [SAMPLE_W-1:0]   h;
  logic [SAMPLE_W-1:0]   wave_p0;
  logic                  unused_bits;

  assign m = phase[PHASE_W-1];
  assign p = phase[PHASE_W-1 -: SAMPLE_W];
  assign x = phase[PHASE_W-2 -: SAMPLE_W];

  // Full-width product so the parabola keeps every bit before the shift.
  assign prod    = {{SAMPLE_W{1'b0}}, x} * {{SAMPLE_W{1'b0}}, FULL - x};
  assign prod_sh = prod >> (SAMPLE_W - 1);
  assign h_sat   = sine_clamp(32'(prod_sh), SAMPLE_W);
  assign h       = h_sat[SAMPLE_W-1:0];

  assign unused_bits = ^{phase, h_sat};

  always_comb begin
    wave_p0 = p;
    case (wave_sel)
      WAVE_SAW: wave_p0 = p;
      WAVE_SQR: wave_p0 = m ? '0 : FULL;
      WAVE_TRI: wave_p0 = m ? ~x : x;
      WAVE_SIN: wave_p0 = m ? (HALF_M1 - h) : (HALF + h);
      default:  wave_p0 = p;
    endcase
  end

  // p0 -> p1: registered sample
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) wave_p1 <= '0;
    else         wave_p1 <= wave_p0;
  end

endmodule

// File: rtl/wavegen_pwm_mc.sv
// Multi-channel phase-accumulator synthesiser; all channels share one PWM period counter.
module wavegen_pwm_mc
  import wavegen_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int PHASE_W  = 16,
  parameter int FREQ_W   = 12,
  parameter int SAMPLE_W = 8,
  parameter int LED_DIV  = 6
) (
  input  logic            clock,
  input  logic            resetn,
  wavegen_pwm_mc_if.slave bus
);

  localparam logic [SAMPLE_W-1:0] CNT_MAX = '1;

  logic [NCH-1:0][PHASE_W-1:0]  acc_p0;
  logic [NCH-1:0][SAMPLE_W-1:0] wave_p1;
  logic [NCH-1:0][SAMPLE_W-1:0] duty_p2;
  logic [SAMPLE_W-1:0]          cnt;
  logic [NCH-1:0]               pwm_q;
  logic                         tick_q;
  logic [NCH-1:0][LED_DIV-1:0]  led_cnt;
  logic [NCH-1:0]               seen;
  logic [NCH-1:0]               act_led_q;
  logic                         period_end;

  assign period_end = bus.en && (cnt == CNT_MAX);

  // p0: phase accumulators; clear wins over run enable
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc_p0 <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (bus.phase_clr)  acc_p0[c] <= '0;
        else if (bus.en)    acc_p0[c] <= acc_p0[c] + PHASE_W'(bus.freq[c*FREQ_W +: FREQ_W]);
      end
    end
  end

  // p0 -> p1: per-channel waveform shaping
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    wave_shaper #(
      .PHASE_W  (PHASE_W),
      .SAMPLE_W (SAMPLE_W)
    ) u_shaper (
      .clock    (clock),
      .resetn   (resetn),
      .phase    (acc_p0[c]),
      .wave_sel (bus.wave_sel[2*c +: 2]),
      .wave_p1  (wave_p1[c])
    );
  end

  // p1 -> p2: duty latched on the last count of a period, then compared against the shared counter
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt     <= '0;
      tick_q  <= 1'b0;
      duty_p2 <= '0;
      pwm_q   <= '0;
    end else begin
      cnt    <= bus.en ? cnt + 1'b1 : '0;
      tick_q <= bus.en && (cnt == '0);
      for (int c = 0; c < NCH; c++) begin
        if (period_end) duty_p2[c] <= wave_p1[c];
        pwm_q[c] <= bus.en && (cnt < duty_p2[c]);
      end
    end
  end

  // Activity LED: the tick cycle already carries the first bit of the next span.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      led_cnt   <= '0;
      seen      <= '0;
      act_led_q <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (tick_q) led_cnt[c] <= led_cnt[c] + LED_DIV'(1);
        if (tick_q && (&led_cnt[c])) begin
          if (seen[c]) act_led_q[c] <= ~act_led_q[c];
          seen[c] <= pwm_q[c];
        end else begin
          seen[c] <= seen[c] | pwm_q[c];
        end
      end
    end
  end

  assign bus.pwm         = pwm_q;
  assign bus.sample      = duty_p2;
  assign bus.period_tick = tick_q;
  assign bus.act_led     = act_led_q;

endmodule

// File: tb/tb_wavegen_pwm_mc.sv
// Bench for wavegen_pwm_mc: per-period duty scoreboard fed from an independent waveform model.
module tb_wavegen_pwm_mc;

  localparam int NCH = 2;
  localparam int FW  = 12;
  localparam int SW  = 8;
  localparam int PER = 256;

  logic clock = 1'b0;
  logic resetn;
  int   checks   = 0;
  int   failures = 0;
  int   exp_q[NCH][$];

  always #5 clock = ~clock;

  wavegen_pwm_mc_if #(.NCH(NCH), .FREQ_W(FW), .SAMPLE_W(SW)) bus ();

  wavegen_pwm_mc dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  // Waveform formulas for a 16-bit phase and 8-bit samples.
  function automatic int wave_model(input int sel, input int ph);
    int m, p, x, h;
    m = (ph >> 15) & 1;
    p = (ph >> 8) & 255;
    x = (ph >> 7) & 255;
    h = (x * (255 - x)) >> 7;
    if (h > 127) h = 127;
    case (sel)
      0:       return p;
      1:       return (m != 0) ? 0 : 255;
      2:       return (m != 0) ? 255 - x : x;
      default: return (m != 0) ? 127 - h : 128 + h;
    endcase
  endfunction

  // Duty of a period whose latch used the phase after `edges` enabled clock edges.
  function automatic int exp_duty(input int sel, input int f, input int edges);
    return wave_model(sel, (edges * f) & 65535);
  endfunction

  task automatic set_ch(input int c, input int f, input int sel);
    bus.freq[c*FW +: FW]   = FW'(f);
    bus.wave_sel[c*2 +: 2] = 2'(sel);
  endtask

  task automatic do_reset();
    bus.en        = 1'b0;
    bus.phase_clr = 1'b0;
    @(negedge clock);
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic wait_tick(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (bus.period_tick !== 1'b1 && n < budget);
  endtask

  // Observes one PWM period starting at the current (tick) cycle; no judging here.
  task automatic collect_period(output logic [NCH-1:0][8:0] hi, output logic [NCH-1:0][SW-1:0] samp,
                                output logic [NCH-1:0] led_mid, output int tick_bad);
    hi       = '0;
    samp     = '0;
    led_mid  = '0;
    tick_bad = 0;
    for (int i = 0; i < PER; i++) begin
      if (i == 0) samp = bus.sample;
      if (i == PER / 2) led_mid = bus.act_led;
      if (bus.period_tick !== (i == 0)) tick_bad++;
      for (int c = 0; c < NCH; c++) hi[c] = hi[c] + 9'(bus.pwm[c]);
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    logic [NCH-1:0][8:0]    hi;
    logic [NCH-1:0][SW-1:0] samp;
    logic [NCH-1:0]         led;
    int tb, n, e;
    set_ch(0, 0, 0);
    set_ch(1, 0, 0);
    bus.en = 1'b0;
    bus.phase_clr = 1'b0;
    resetn = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if ({bus.pwm, bus.period_tick, bus.act_led} !== '0) begin
      failures++;
      $display("FAIL reset_ctl: pwm=%b tick=%b led=%b required 0", bus.pwm, bus.period_tick, bus.act_led);
    end
    checks++;
    if (bus.sample !== '0) begin
      failures++;
      $display("FAIL reset_sample: got %h required 0", bus.sample);
    end
    resetn = 1'b1;
    bus.en = 1'b1;
    wait_tick(4, n);
    checks++;
    if (bus.period_tick !== 1'b1 || n != 1) begin
      failures++;
      $display("FAIL reset_first_tick: waited %0d tick=%b required 1 cycle", n, bus.period_tick);
    end
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < NCH; c++) exp_q[c].push_back(0);
    for (int k = 0; k < 3; k++) begin
      collect_period(hi, samp, led, tb);
      checks++;
      if (tb != 0) begin
        failures++;
        $display("FAIL reset_tick_spacing p%0d: %0d bad tick cycles required 0", k, tb);
      end
      for (int c = 0; c < NCH; c++) begin
        e = exp_q[c].pop_front();
        checks++;
        if (hi[c] !== 9'(e) || samp[c] !== SW'(e)) begin
          failures++;
          $display("FAIL reset_idle p%0d ch%0d: high=%0d sample=%0d required %0d", k, c, hi[c], samp[c], e);
        end
      end
    end
    checks++;
    if (bus.act_led !== '0) begin
      failures++;
      $display("FAIL reset_led_idle: got %b required 00", bus.act_led);
    end
  endtask

  task automatic test_square();
    logic [NCH-1:0][8:0]    hi;
    logic [NCH-1:0][SW-1:0] samp;
    logic [NCH-1:0]         led;
    int tb, n, e;
    int f[NCH], s[NCH];
    do_reset();
    f[0] = 1;   s[0] = 0;
    f[1] = 128; s[1] = 1;
    for (int c = 0; c < NCH; c++) set_ch(c, f[c], s[c]);
    bus.en = 1'b1;
    wait_tick(4, n);
    checks++;
    if (bus.period_tick !== 1'b1 || n != 1) begin
      failures++;
      $display("FAIL square_first_tick: waited %0d required 1", n);
    end
    for (int k = 0; k < 6; k++)
      for (int c = 0; c < NCH; c++) exp_q[c].push_back(k == 0 ? 0 : exp_duty(s[c], f[c], PER * k - 2));
    for (int k = 0; k < 6; k++) begin
      collect_period(hi, samp, led, tb);
      checks++;
      if (tb != 0) begin
        failures++;
        $display("FAIL square_tick p%0d: %0d bad tick cycles", k, tb);
      end
      for (int c = 0; c < NCH; c++) begin
        e = exp_q[c].pop_front();
        checks++;
        if (hi[c] !== 9'(e) || samp[c] !== SW'(e)) begin
          failures++;
          $display("FAIL square_duty p%0d ch%0d: high=%0d sample=%0d required %0d", k, c, hi[c], samp[c], e);
        end
      end
    end
  endtask

  task automatic test_waveforms();
    logic [NCH-1:0][8:0]    hi;
    logic [NCH-1:0][SW-1:0] samp;
    logic [NCH-1:0]         led;
    int tb, n, e;
    int sel_tab[2][NCH] = '{'{0, 1}, '{2, 3}};
    int f_run[NCH] = '{300, 777};
    do_reset();
    set_ch(0, f_run[0], 0);
    set_ch(1, f_run[1], 3);
    bus.en = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      for (int c = 0; c < NCH; c++) set_ch(c, f_run[c], sel_tab[pass][c]);
      repeat (20) @(negedge clock);
      bus.phase_clr = 1'b1;
      @(negedge clock);
      bus.phase_clr = 1'b0;
      bus.en = 1'b0;
      for (int c = 0; c < NCH; c++) set_ch(c, 0, sel_tab[pass][c]);
      @(negedge clock);
      bus.en = 1'b1;
      wait_tick(4, n);
      checks++;
      if (bus.period_tick !== 1'b1 || n != 1) begin
        failures++;
        $display("FAIL wave_first_tick pass%0d: waited %0d required 1", pass, n);
      end
      for (int c = 0; c < NCH; c++) begin
        exp_q[c].push_back(-1);
        exp_q[c].push_back(wave_model(sel_tab[pass][c], 0));
        exp_q[c].push_back(wave_model(sel_tab[pass][c], 0));
      end
      for (int k = 0; k < 3; k++) begin
        collect_period(hi, samp, led, tb);
        for (int c = 0; c < NCH; c++) begin
          e = exp_q[c].pop_front();
          if (e >= 0) begin
            checks++;
            if (hi[c] !== 9'(e) || samp[c] !== SW'(e)) begin
              failures++;
              $display("FAIL wave_zero_phase pass%0d p%0d ch%0d sel%0d: high=%0d sample=%0d required %0d",
                       pass, k, c, sel_tab[pass][c], hi[c], samp[c], e);
            end
          end
        end
      end
    end
  endtask

  task automatic test_enable_and_async_reset();
    logic [NCH-1:0][8:0]    hi;
    logic [NCH-1:0][SW-1:0] samp;
    logic [NCH-1:0]         led;
    int tb, n, e;
    int f[NCH], s[NCH];
    do_reset();
    f[0] = 300;  s[0] = 0;
    f[1] = 1000; s[1] = 2;
    for (int c = 0; c < NCH; c++) set_ch(c, f[c], s[c]);
    bus.en = 1'b1;
    wait_tick(4, n);
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < NCH; c++) exp_q[c].push_back(k == 0 ? 0 : exp_duty(s[c], f[c], PER * k - 2));
    for (int k = 0; k < 3; k++) begin
      collect_period(hi, samp, led, tb);
      for (int c = 0; c < NCH; c++) begin
        e = exp_q[c].pop_front();
        checks++;
        if (hi[c] !== 9'(e) || samp[c] !== SW'(e)) begin
          failures++;
          $display("FAIL en_pre p%0d ch%0d: high=%0d sample=%0d required %0d", k, c, hi[c], samp[c], e);
        end
      end
    end
    // now one cycle into period 3 (cnt=1); move to cnt=100 after 868 enabled edges
    repeat (99) @(negedge clock);
    bus.en = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.pwm !== '0 || bus.period_tick !== 1'b0) begin
      failures++;
      $display("FAIL en_drop_pwm: pwm=%b tick=%b required 0", bus.pwm, bus.period_tick);
    end
    repeat (9) @(negedge clock);
    for (int c = 0; c < NCH; c++) begin
      e = exp_duty(s[c], f[c], 3 * PER - 2);
      checks++;
      if (bus.sample[c*SW +: SW] !== SW'(e)) begin
        failures++;
        $display("FAIL en_duty_retained ch%0d: got %0d required %0d", c, bus.sample[c*SW +: SW], e);
      end
    end
    bus.en = 1'b1;
    wait_tick(4, n);
    checks++;
    if (bus.period_tick !== 1'b1 || n != 1) begin
      failures++;
      $display("FAIL en_resume_tick: waited %0d required 1", n);
    end
    for (int k = 0; k < 3; k++)
      for (int c = 0; c < NCH; c++)
        exp_q[c].push_back(k == 0 ? exp_duty(s[c], f[c], 3 * PER - 2) : exp_duty(s[c], f[c], 868 + PER * k - 2));
    for (int k = 0; k < 3; k++) begin
      collect_period(hi, samp, led, tb);
      checks++;
      if (tb != 0) begin
        failures++;
        $display("FAIL en_resume_spacing p%0d: %0d bad tick cycles", k, tb);
      end
      for (int c = 0; c < NCH; c++) begin
        e = exp_q[c].pop_front();
        checks++;
        if (hi[c] !== 9'(e) || samp[c] !== SW'(e)) begin
          failures++;
          $display("FAIL en_frozen_phase p%0d ch%0d: high=%0d sample=%0d required %0d", k, c, hi[c], samp[c], e);
        end
      end
    end
    repeat (50) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({bus.pwm, bus.period_tick, bus.act_led, bus.sample} !== '0) begin
      failures++;
      $display("FAIL async_reset: pwm=%b tick=%b led=%b sample=%h required 0",
               bus.pwm, bus.period_tick, bus.act_led, bus.sample);
    end
    @(negedge clock);
    resetn = 1'b1;
    wait_tick(4, n);
    checks++;
    if (bus.period_tick !== 1'b1 || n != 1) begin
      failures++;
      $display("FAIL reset_release_tick: waited %0d required 1", n);
    end
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < NCH; c++) exp_q[c].push_back(k == 0 ? 0 : exp_duty(s[c], f[c], PER - 2));
    for (int k = 0; k < 2; k++) begin
      collect_period(hi, samp, led, tb);
      for (int c = 0; c < NCH; c++) begin
        e = exp_q[c].pop_front();
        checks++;
        if (hi[c] !== 9'(e) || samp[c] !== SW'(e)) begin
          failures++;
          $display("FAIL post_reset p%0d ch%0d: high=%0d sample=%0d required %0d", k, c, hi[c], samp[c], e);
        end
      end
    end
  endtask

  task automatic test_saw_sine_long();
    logic [NCH-1:0][8:0]    hi;
    logic [NCH-1:0][SW-1:0] samp;
    logic [NCH-1:0]         led;
    int tb, n, e, bad;
    int smax, smin;
    int f[NCH], s[NCH];
    do_reset();
    f[0] = 1; s[0] = 0;
    f[1] = 1; s[1] = 3;
    for (int c = 0; c < NCH; c++) set_ch(c, f[c], s[c]);
    bus.en = 1'b1;
    wait_tick(4, n);
    checks++;
    if (bus.period_tick !== 1'b1 || n != 1) begin
      failures++;
      $display("FAIL long_first_tick: waited %0d required 1", n);
    end
    for (int k = 0; k < 258; k++)
      for (int c = 0; c < NCH; c++) exp_q[c].push_back(k == 0 ? 0 : exp_duty(s[c], f[c], PER * k - 2));
    smax = -1;
    smin = 1000;
    bad  = 0;
    for (int k = 0; k < 258; k++) begin
      collect_period(hi, samp, led, tb);
      if (tb != 0) bad++;
      if (k >= 1) begin
        if (int'(hi[1]) > smax) smax = int'(hi[1]);
        if (int'(hi[1]) < smin) smin = int'(hi[1]);
      end
      for (int c = 0; c < NCH; c++) begin
        e = exp_q[c].pop_front();
        checks++;
        if (hi[c] !== 9'(e) || samp[c] !== SW'(e)) begin
          failures++;
          $display("FAIL long_duty p%0d ch%0d: high=%0d sample=%0d required %0d", k, c, hi[c], samp[c], e);
        end
      end
      if (k == 100 || k == 150) begin
        checks++;
        if (led !== ((k == 100) ? 2'b11 : 2'b00)) begin
          failures++;
          $display("FAIL act_led p%0d: got %b required %b", k, led, (k == 100) ? 2'b11 : 2'b00);
        end
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL long_tick_spacing: %0d periods with bad ticks required 0", bad);
    end
    checks++;
    if (smax != 255 || smin != 0) begin
      failures++;
      $display("FAIL sine_extremes: max=%0d min=%0d required 255 and 0", smax, smin);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn        = 1'b0;
    bus.en        = 1'b0;
    bus.phase_clr = 1'b0;
    bus.freq      = '0;
    bus.wave_sel  = '0;
    test_reset();
    test_square();
    test_waveforms();
    test_enable_and_async_reset();
    test_saw_sine_long();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
